// File: rtl/cpu_cache_req_queue_if.sv
// Request/response bus between the CPU port, the request queue and the cache controller.
// The queue takes the slave view; the CPU and cache models take the master view.
interface cpu_cache_req_queue_if #(
    parameter int ADDR_SIZE = 16,
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4
);
    logic [ADDR_SIZE-1:0]        sys_addr;
    logic [WORD_SIZE-1:0]        sys_wdata;
    logic [WORD_SIZE/8-1:0]      sys_bval;
    logic                        sys_rd;
    logic                        sys_wr;
    logic                        sys_ready;
    logic                        sys_ack;
    logic                        sys_err;
    logic [WORD_SIZE-1:0]        sys_rdata;
    logic [$clog2(DEPTH+1)-1:0]  req_count;
    logic [ADDR_SIZE-1:0]        cache_addr;
    logic [WORD_SIZE-1:0]        cache_wdata;
    logic [WORD_SIZE/8-1:0]      cache_bval;
    logic                        cache_rd;
    logic                        cache_wr;
    logic                        cache_ack;
    logic [WORD_SIZE-1:0]        cache_rdata;

    modport slave (
        input  sys_addr, sys_wdata, sys_bval, sys_rd, sys_wr, cache_ack, cache_rdata,
        output sys_ready, sys_ack, sys_err, sys_rdata, req_count,
               cache_addr, cache_wdata, cache_bval, cache_rd, cache_wr
    );

    modport master (
        output sys_addr, sys_wdata, sys_bval, sys_rd, sys_wr, cache_ack, cache_rdata,
        input  sys_ready, sys_ack, sys_err, sys_rdata, req_count,
               cache_addr, cache_wdata, cache_bval, cache_rd, cache_wr
    );
endinterface

// File: rtl/cpu_cache_req_queue.sv
// In-order CPU request FIFO feeding the cache one request at a time, with
// backpressure, optional posted writes and a per-request timeout abort.
module cpu_cache_req_queue #(
    parameter int ADDR_SIZE      = 16,
    parameter int WORD_SIZE      = 32,
    parameter int DEPTH          = 4,
    parameter bit POSTED_WR      = 1'b1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    cpu_cache_req_queue_if.slave bus
);
    localparam int BE_W  = WORD_SIZE / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    logic                 fifo_wr_op [DEPTH];
    logic [ADDR_SIZE-1:0] fifo_addr  [DEPTH];
    logic [WORD_SIZE-1:0] fifo_wdata [DEPTH];
    logic [BE_W-1:0]      fifo_bval  [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    state_t               state;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 cur_wr;
    logic                 cache_rd_q;
    logic                 cache_wr_q;
    logic [ADDR_SIZE-1:0] cache_addr_q;
    logic [WORD_SIZE-1:0] cache_wdata_q;
    logic [BE_W-1:0]      cache_bval_q;
    logic                 sys_ack_q;
    logic                 sys_err_q;
    logic [WORD_SIZE-1:0] sys_rdata_q;

    logic ready;
    logic push;
    logic pop;
    logic both_req;

    // Readiness comes only from the registered count, so a full FIFO never
    // accepts even when the head is popped in the same cycle.
    assign ready    = (count != CNT_FULL);
    assign push     = ready && (bus.sys_rd || bus.sys_wr);
    assign both_req = ready && bus.sys_rd && bus.sys_wr;
    assign pop      = (state == ST_IDLE) && (count != '0);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_wr_op[wr_ptr] <= bus.sys_wr;
            fifo_addr[wr_ptr]  <= bus.sys_addr;
            fifo_wdata[wr_ptr] <= bus.sys_wdata;
            fifo_bval[wr_ptr]  <= bus.sys_bval;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            cur_wr        <= 1'b0;
            cache_rd_q    <= 1'b0;
            cache_wr_q    <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            cache_bval_q  <= '0;
            sys_ack_q     <= 1'b0;
            sys_err_q     <= 1'b0;
            sys_rdata_q   <= '0;
        end else begin
            cache_rd_q <= 1'b0;
            cache_wr_q <= 1'b0;
            sys_ack_q  <= 1'b0;
            sys_err_q  <= both_req;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_wr        <= fifo_wr_op[rd_ptr];
                        cache_rd_q    <= !fifo_wr_op[rd_ptr];
                        cache_wr_q    <= fifo_wr_op[rd_ptr];
                        cache_addr_q  <= fifo_addr[rd_ptr];
                        cache_wdata_q <= fifo_wdata[rd_ptr];
                        cache_bval_q  <= fifo_bval[rd_ptr];
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack landing on the last timeout cycle still completes normally.
                    if (bus.cache_ack) begin
                        state <= ST_IDLE;
                        if (!cur_wr) begin
                            sys_ack_q   <= 1'b1;
                            sys_rdata_q <= bus.cache_rdata;
                        end else if (!POSTED_WR) begin
                            sys_ack_q <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ST_IDLE;
                        sys_err_q <= 1'b1;
                        if (!cur_wr) begin
                            sys_ack_q   <= 1'b1;
                            sys_rdata_q <= '0;
                        end else if (!POSTED_WR) begin
                            sys_ack_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sys_ready   = ready;
    assign bus.sys_ack     = sys_ack_q;
    assign bus.sys_err     = sys_err_q;
    assign bus.sys_rdata   = sys_rdata_q;
    assign bus.req_count   = count;
    assign bus.cache_addr  = cache_addr_q;
    assign bus.cache_wdata = cache_wdata_q;
    assign bus.cache_bval  = cache_bval_q;
    assign bus.cache_rd    = cache_rd_q;
    assign bus.cache_wr    = cache_wr_q;
endmodule
